// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for mem_ctrl: FSM state encoding, transaction
// owner codes, access length codes, bus widths and small byte helpers.
package mem_ctrl_pkg;

  localparam int RegBus  = 32;
  localparam int DataBus = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OwnerNone = 2'd0,
    OwnerIf   = 2'd1,
    OwnerMem  = 2'd2
  } owner_e;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  // Number of bytes moved for a length code; the unused code 11 is a word.
  function automatic logic [2:0] lenToBytes(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Little-endian byte lane idx of a word.
  function automatic logic [DataBus-1:0] byteOf(input logic [RegBus-1:0] word,
                                                input logic [1:0] idx);
    return word[{idx, 3'b000} +: DataBus];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide synchronous RAM port between instruction
// fetch (4-byte reads) and stage_mem (1/2/4-byte loads and stores). Each
// request is split into little-endian byte accesses; read bytes are gathered
// into a word and a one-cycle ready pulse marks completion.
// Optional build macro MEM_CTRL_RR_EN: round-robin grant on simultaneous
// requests instead of fixed MEM priority.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ready_o,
  output logic [31:0] if_data_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_len_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ready_o,
  output logic [31:0] mem_rdata_o,
  input  logic [7:0]  ram_din_i,
  output logic [7:0]  ram_dout_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o
);

  // The capture schedule below assumes read data one cycle after the address.
  if (RD_LAT != 1) begin : gen_rd_lat_check
    $error("mem_ctrl: only RD_LAT == 1 is supported");
  end

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  logic                 we_q, we_d;
  logic [2:0]           nbytes_q, nbytes_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [RegBus-1:0]    addr_q, addr_d;
  logic [RegBus-1:0]    wdata_q, wdata_d;
  logic [RegBus-1:0]    res_q, res_d;
  logic [RegBus-1:0]    ram_a_q, ram_a_d;
  logic [DataBus-1:0]   ram_dout_q, ram_dout_d;
  logic                 ram_wr_q, ram_wr_d;
  logic                 if_ready_q, if_ready_d;
  logic                 mem_ready_q, mem_ready_d;
  logic [RegBus-1:0]    if_data_q, if_data_d;
  logic [RegBus-1:0]    mem_rdata_q, mem_rdata_d;
  logic                 grant_any;
  logic                 grant_mem;
  logic [1:0]           cap_idx;
  logic [RegBus-1:0]    addr_k;
`ifdef MEM_CTRL_RR_EN
  owner_e               last_grant_q, last_grant_d;
`endif

  // Arbiter decision: who would be granted if the FSM is idle this cycle.
  always_comb begin
    grant_any = if_req_i | mem_req_i;
    grant_mem = mem_req_i;
`ifdef MEM_CTRL_RR_EN
    if (if_req_i && mem_req_i) begin
      grant_mem = (last_grant_q == OwnerIf);
    end
`endif
  end

  // Transaction sequencing: grant, per-byte address/data stepping, read
  // assembly, IF abort and the one-cycle completion pulse.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    res_d       = res_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    cap_idx     = cnt_q[1:0] - 2'd2;
    addr_k      = addr_q + RegBus'(cnt_q);
`ifdef MEM_CTRL_RR_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (grant_any) begin
          owner_d    = grant_mem ? OwnerMem : OwnerIf;
          addr_d     = grant_mem ? mem_addr_i : if_addr_i;
          nbytes_d   = grant_mem ? lenToBytes(mem_len_i) : 3'd4;
          we_d       = grant_mem & mem_we_i;
          wdata_d    = mem_wdata_i;
          res_d      = '0;
          ram_a_d    = grant_mem ? mem_addr_i : if_addr_i;
          ram_wr_d   = grant_mem & mem_we_i;
          ram_dout_d = (grant_mem && mem_we_i) ? mem_wdata_i[7:0] : 8'h00;
          cnt_d      = 3'd1;
          state_d    = StRun;
`ifdef MEM_CTRL_RR_EN
          last_grant_d = grant_mem ? OwnerMem : OwnerIf;
`endif
        end
      end

      StRun: begin
        if (owner_q == OwnerIf && !if_req_i) begin
          state_d    = StIdle;
          owner_d    = OwnerNone;
          ram_a_d    = '0;
          ram_wr_d   = 1'b0;
          ram_dout_d = '0;
        end else if (we_q) begin
          if (cnt_q < nbytes_q) begin
            ram_a_d    = addr_k;
            ram_dout_d = byteOf(wdata_q, cnt_q[1:0]);
            cnt_d      = cnt_q + 3'd1;
          end else begin
            ram_wr_d    = 1'b0;
            ram_a_d     = '0;
            ram_dout_d  = '0;
            mem_ready_d = 1'b1;
            state_d     = StDone;
          end
        end else begin
          if (cnt_q >= 3'd2) begin
            res_d[{cap_idx, 3'b000} +: DataBus] = ram_din_i;
          end
          ram_a_d = (cnt_q < nbytes_q) ? addr_k : '0;
          if (cnt_q == nbytes_q + 3'd1) begin
            if (owner_q == OwnerMem) begin
              mem_rdata_d = res_d;
              mem_ready_d = 1'b1;
            end else begin
              if_data_d  = res_d;
              if_ready_d = 1'b1;
            end
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        owner_d = OwnerNone;
      end

      default: begin
        state_d = StIdle;
        owner_d = OwnerNone;
      end
    endcase
  end

  // State and output registers with synchronous reset to an all-zero idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnerNone;
      we_q        <= 1'b0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      res_q       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
`ifdef MEM_CTRL_RR_EN
      last_grant_q <= OwnerIf;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      res_q       <= res_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef MEM_CTRL_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign if_ready_o  = if_ready_q;
  assign if_data_o   = if_data_q;
  assign mem_ready_o = mem_ready_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_a_o     = ram_a_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_wr_o    = ram_wr_q;

endmodule
